kogge_stone_pipe: RTL
=====================

Name: kogge_stone_pipe

Overview:
Parametrised, pipelined Kogge-Stone adder/subtractor/comparator for the integer execution lanes of the superscalar core. It is the successor to the fixed 32-bit combinational Kogge-Stone adder. Changes from that block: configurable width and pipeline depth, an op mode, a correct flag set, a tag pass-through for ROB tracking, and valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width; power of two, 8..128
STAGES, 2, pipeline register ranks = accept-to-output latency in cycles; 1..clog2(WIDTH)+1
TAG_W, 6, width of opaque tag carried alongside each operation

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  2  ks_op_t: ADD=0, SUB=1, SLT=2, SLTU=3
in_tag  in  TAG_W  tag, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_result  out  WIDTH  result
out_flags  out  4  {carry, overflow, zero, negative}
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: all stage valid bits cleared asynchronously.
  - out_valid=0; out_result, out_flags, out_tag = 0.
  - in_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation: in-flight operations are discarded; none emerge after reset.
- Transfer rules: input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled.
- Throughput: 1 op/cycle.
- Stall: stall = out_valid & ~out_ready.
  - Stall freezes every stage (global stall, no bubble collapse).
  - in_ready = ~stall (combinational).
  - Outputs hold stable while stalled.
- Ordering: results leave in acceptance order; no drop, no duplication.
- Prefix structure: LEVELS = clog2(WIDTH) prefix levels.
  - Stage-0 logic: B' = B ^ {WIDTH{sub}}, cin = sub.
  - sub = 1 for SUB, SLT and SLTU.
  - Register ranks: after prefix levels round(j*LEVELS/STAGES), j=1..STAGES-1, plus a mandatory output rank.
  - STAGES=1 gives a fully combinational datapath into one output register.
- Arithmetic: S = A + B' + cin modulo 2^WIDTH.
  - carry = carry out of MSB; for SUB, carry=1 means no borrow.
  - overflow = (A[W-1]==B'[W-1]) & (S[W-1]!=A[W-1]).
- Result by op:
  - ADD/SUB: S.
  - SLT: zero-extended (S[W-1]^overflow).
  - SLTU: zero-extended (~carry).
- Flags: zero = (out_result==0), negative = out_result[W-1]. For SLT/SLTU, carry and overflow reflect the internal subtraction.
- Simultaneous events: same-cycle output pop and input push are permitted whenever out_ready=1.

Optional Feature:
KS_PIPE_FLUSH_EN:
- Defined: adds input port flush (1 bit).
  - flush=1 clears all stage valid bits on the next edge and has priority over stall.
  - An op offered in the same cycle as flush is not accepted; in_ready=0 while flush=1.
  - out_valid=0 the cycle after flush.
- Undefined: no flush port; pipeline drains only via out_ready.

Decomposition:
- Package ks_pkg holds:
  - ks_op_t enum.
  - ks_flags_t packed struct {carry, overflow, zero, negative}.
  - Function ks_levels(WIDTH).
  - Function ks_cut(j, LEVELS, STAGES) returning the prefix level after register rank j.
- Sub-module ks_prefix_level(WIDTH, DIST):
  - One combinational Kogge-Stone level.
  - Black cell (G,P) ∘ (G',P') for bits ≥ DIST; pass-through below.
  - Instantiated LEVELS times with DIST = 2^k.
- Top level owns: operand preconditioning, stage registers, handshake, result mux and flags.

Test Plan:
- WIDTH=32, STAGES=2: ADD 0x7FFFFFFF+0x00000001 → after 2 cycles result 0x80000000, flags {c0,v1,z0,n1}, tag echoed.
- SUB 0x00000000-0x00000001 → 0xFFFFFFFF, {c0,v0,z0,n1}; SUB 5-5 → 0, {c1,v0,z1,n0}.
- SLT A=0xFFFFFFFF, B=1 → 1; SLTU same operands → 0; SLT 0x80000000 vs 0x7FFFFFFF → 1.
- Stream 8 back-to-back ops, out_ready=0 for cycles 3-5:
  - in_ready=0 exactly while stalled.
  - 8 results in order with correct tags; held values stable while stalled.
- Two ops in flight, pulse rst for 1 cycle → out_valid=0 immediately; no result emerges afterward; next op returns normally after STAGES cycles.
- Parameter sweep WIDTH∈{8,32,64,128} × STAGES∈{1,3,clog2(WIDTH)+1}: 10k random ops with random backpressure vs behavioural model → zero mismatches; latency equals STAGES.

Source files
------------

// File: rtl/kogge_stone_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder/comparator.
package ks_pkg;

    typedef enum logic [1:0] {
        KS_ADD  = 2'd0,
        KS_SUB  = 2'd1,
        KS_SLT  = 2'd2,
        KS_SLTU = 2'd3
    } ks_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } ks_flags_t;

    function automatic int ks_levels(input int width);
        return $clog2(width);
    endfunction

    // Prefix level boundary after register rank j, rounded half-up.
    function automatic int ks_cut(input int j, input int levels, input int stages);
        return (2 * j * levels + stages) / (2 * stages);
    endfunction

endpackage

// File: rtl/kogge_stone_pipe_if.sv
// Operation-in / result-out handshake bundle of the Kogge-Stone pipe.
interface kogge_stone_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    import ks_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    ks_op_t           in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    ks_flags_t        out_flags;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_tag
    );
endinterface

// File: rtl/kogge_stone_pipe_prefix_level.sv
// One combinational Kogge-Stone level: black cells at bits >= DIST, pass-through below.
module ks_prefix_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);
    always_comb begin
        g_o = g_i;
        p_o = p_i;
        for (int i = DIST; i < WIDTH; i++) begin
            g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
            p_o[i] = p_i[i] & p_i[i-DIST];
        end
    end
endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone add/sub/compare with tag pass-through and global-stall handshake.
// Optional synchronous flush input enabled by defining KS_PIPE_FLUSH_EN.
module kogge_stone_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input logic clk,
    input logic rst,
`ifdef KS_PIPE_FLUSH_EN
    input logic flush,
`endif
    kogge_stone_pipe_if.slave bus
);
    localparam int LEVELS = ks_levels(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        logic             cin;
        logic             aMsb;
        logic             bMsb;
        ks_op_t           op;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           stage_in [0:STAGES-1];
    logic             valid_in [0:STAGES-1];
    stage_t           stage0;
    logic             sub;
    logic [WIDTH-1:0] bMod;
    logic             stall;
    logic             flushNow;

`ifdef KS_PIPE_FLUSH_EN
    assign flushNow = flush;
`else
    assign flushNow = 1'b0;
`endif

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~flushNow;

    // Carry-in folds into bit 0 generate so the prefix tree yields true carries directly.
    always_comb begin
        sub          = (bus.in_op != KS_ADD);
        bMod         = bus.in_b ^ {WIDTH{sub}};
        stage0       = '0;
        stage0.x     = bus.in_a ^ bMod;
        stage0.p     = stage0.x;
        stage0.g     = bus.in_a & bMod;
        stage0.g[0]  = (bus.in_a[0] & bMod[0]) | (stage0.x[0] & sub);
        stage0.cin   = sub;
        stage0.aMsb  = bus.in_a[WIDTH-1];
        stage0.bMsb  = bMod[WIDTH-1];
        stage0.op    = bus.in_op;
        stage0.tag   = bus.in_tag;
    end

    assign stage_in[0] = stage0;
    assign valid_in[0] = bus.in_valid & bus.in_ready;

    for (genvar r = 0; r < STAGES; r++) begin : g_rank
        localparam int LO = (r == 0) ? 0 : ks_cut(r, LEVELS, STAGES);
        localparam int HI = (r == STAGES - 1) ? LEVELS : ks_cut(r + 1, LEVELS, STAGES);
        localparam int NL = HI - LO;

        logic [WIDTH-1:0] gL [0:NL];
        logic [WIDTH-1:0] pL [0:NL];

        assign gL[0] = stage_in[r].g;
        assign pL[0] = stage_in[r].p;

        for (genvar k = 0; k < NL; k++) begin : g_lvl
            ks_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (LO + k))
            ) u_lvl (
                .g_i (gL[k]),
                .p_i (pL[k]),
                .g_o (gL[k+1]),
                .p_o (pL[k+1])
            );
        end

        if (r < STAGES - 1) begin : g_mid
            stage_t stage_d;
            stage_t stage_q;
            logic   valid_q;

            always_comb begin
                stage_d   = stage_in[r];
                stage_d.g = gL[NL];
                stage_d.p = pL[NL];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    stage_q <= '0;
                end else if (flushNow) begin
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    valid_q <= valid_in[r];
                    stage_q <= stage_d;
                end
            end

            assign stage_in[r+1] = stage_q;
            assign valid_in[r+1] = valid_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum;
            logic             ovf;
            logic [WIDTH-1:0] result_d;
            ks_flags_t        flags_d;
            logic             valid_q;
            logic [WIDTH-1:0] result_q;
            ks_flags_t        flags_q;
            logic [TAG_W-1:0] tag_q;

            // SLT/SLTU reuse the subtraction's carry/overflow; zero/negative follow the final result.
            always_comb begin
                sum            = stage_in[r].x ^ {gL[NL][WIDTH-2:0], stage_in[r].cin};
                ovf            = (stage_in[r].aMsb == stage_in[r].bMsb) &
                                 (sum[WIDTH-1] != stage_in[r].aMsb);
                flags_d        = '0;
                flags_d.carry    = gL[NL][WIDTH-1];
                flags_d.overflow = ovf;
                result_d       = sum;
                case (stage_in[r].op)
                    KS_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                    KS_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~gL[NL][WIDTH-1]};
                    default: result_d = sum;
                endcase
                flags_d.zero     = (result_d == '0);
                flags_d.negative = result_d[WIDTH-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q  <= 1'b0;
                    result_q <= '0;
                    flags_q  <= '0;
                    tag_q    <= '0;
                end else if (flushNow) begin
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    valid_q  <= valid_in[r];
                    result_q <= result_d;
                    flags_q  <= flags_d;
                    tag_q    <= stage_in[r].tag;
                end
            end

            assign bus.out_valid  = valid_q;
            assign bus.out_result = result_q;
            assign bus.out_flags  = flags_q;
            assign bus.out_tag    = tag_q;
        end
    end
endmodule
